// File: rtl/mul_unit_pkg.sv
// Shared ALU control codes and multiplier FSM state type.
// Consumed by the ALU control decoder, the ALU and mul_unit.
package mul_unit_pkg;

  localparam logic [4:0] ALU_ADD    = 5'h00;
  localparam logic [4:0] ALU_SUB    = 5'h01;
  localparam logic [4:0] ALU_SLL    = 5'h02;
  localparam logic [4:0] ALU_SLT    = 5'h03;
  localparam logic [4:0] ALU_SLTU   = 5'h04;
  localparam logic [4:0] ALU_XOR    = 5'h05;
  localparam logic [4:0] ALU_SRL    = 5'h06;
  localparam logic [4:0] ALU_SRA    = 5'h07;
  localparam logic [4:0] ALU_OR     = 5'h08;
  localparam logic [4:0] ALU_AND    = 5'h09;
  localparam logic [4:0] ALU_COPYB  = 5'h0A;
  localparam logic [4:0] ALU_BEQ    = 5'h0B;
  localparam logic [4:0] ALU_BNE    = 5'h0C;
  localparam logic [4:0] ALU_BLT    = 5'h0D;
  localparam logic [4:0] ALU_BGE    = 5'h0E;
  localparam logic [4:0] ALU_BLTU   = 5'h0F;
  localparam logic [4:0] ALU_BGEU   = 5'h10;
  localparam logic [4:0] ALU_JAL    = 5'h11;
  localparam logic [4:0] ALU_MUL    = 5'h12;
  localparam logic [4:0] ALU_MULH   = 5'h13;
  localparam logic [4:0] ALU_MULHSU = 5'h14;
  localparam logic [4:0] ALU_MULHU  = 5'h15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mul_state_e;

  function automatic logic is_mul(input logic [4:0] code);
    return (code >= ALU_MUL) && (code <= ALU_MULHU);
  endfunction

endpackage

// File: rtl/mul_unit_if.sv
// EX-stage request/response bundle between pipeline and mul_unit.
interface mul_if;
  logic        start;
  logic [4:0]  alu_ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, alu_ctrl, src1, src2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, alu_ctrl, src1, src2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/mul_unit_step.sv
// Combinational BPC-bit partial-product accumulate.
module mul_step #(
  parameter int BPC = 2
) (
  input  logic [63:0]    acc_i,
  input  logic [63:0]    mcand_i,
  input  logic [BPC-1:0] bits_i,
  output logic [63:0]    acc_o
);

  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < BPC; i++) begin
      if (bits_i[i]) acc_o = acc_o + (mcand_i << i);
    end
  end

endmodule

// File: rtl/mul_unit.sv
// Iterative 32x32 multiplier (MUL/MULH/MULHSU/MULHU), BPC bits per cycle.
// Define MUL_FUSE_EN to reuse the last MULH* product for a matching MUL.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int BPC = 2
) (
  input  logic clk,
  input  logic rst,
  mul_if.slave bus
);

  localparam int N  = 32 / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mul_state_e state_q, state_d;

  logic [63:0]   acc_q, acc_nx, mcand_q, prod;
  logic [31:0]   mplier_q, res_q, abs1, abs2;
  logic [4:0]    op_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q, neg1, neg2;
  logic          accept, fuse_hit;

`ifdef MUL_FUSE_EN
  logic [63:0] fprod_q;
  logic [31:0] fsrc1_q, fsrc2_q, src1_q, src2_q;
  logic        fval_q;
`endif

  always_comb begin
    neg1 = (bus.alu_ctrl != ALU_MULHU) && bus.src1[31];
    neg2 = ((bus.alu_ctrl == ALU_MUL) || (bus.alu_ctrl == ALU_MULH))
           && bus.src2[31];
    abs1 = neg1 ? (32'd0 - bus.src1) : bus.src1;
    abs2 = neg2 ? (32'd0 - bus.src2) : bus.src2;
    prod = neg_q ? (64'd0 - acc_q) : acc_q;
  end

  always_comb begin
    accept = ((state_q == S_IDLE) || (state_q == S_DONE))
             && bus.start && is_mul(bus.alu_ctrl) && !bus.flush;
`ifdef MUL_FUSE_EN
    fuse_hit = accept && (bus.alu_ctrl == ALU_MUL) && fval_q
               && (bus.src1 == fsrc1_q) && (bus.src2 == fsrc2_q);
`else
    fuse_hit = 1'b0;
`endif
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (fuse_hit)    state_d = S_DONE;
        else if (accept) state_d = S_CALC;
        else             state_d = S_IDLE;
      end
      S_CALC: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  mul_step #(.BPC(BPC)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bits_i  (mplier_q[BPC-1:0]),
    .acc_o   (acc_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      op_q     <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      if (accept) begin
        acc_q    <= '0;
        mcand_q  <= {32'd0, abs1};
        mplier_q <= abs2;
        neg_q    <= neg1 ^ neg2;
        op_q     <= bus.alu_ctrl;
        cnt_q    <= CW'(N - 1);
      end else if (state_q == S_CALC) begin
        acc_q    <= acc_nx;
        mcand_q  <= mcand_q << BPC;
        mplier_q <= mplier_q >> BPC;
        cnt_q    <= cnt_q - CW'(1);
      end
`ifdef MUL_FUSE_EN
      if (fuse_hit) res_q <= fprod_q[31:0];
      else
`endif
      if ((state_q == S_FIX) && !bus.flush)
        res_q <= (op_q == ALU_MUL) ? prod[31:0] : prod[63:32];
    end
  end

`ifdef MUL_FUSE_EN
  // Fuse store only tracks completed high-word ops; any MUL retires it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fval_q  <= 1'b0;
      fprod_q <= '0;
      fsrc1_q <= '0;
      fsrc2_q <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
    end else begin
      if (accept) begin
        src1_q <= bus.src1;
        src2_q <= bus.src2;
      end
      if (bus.flush || fuse_hit) begin
        fval_q <= 1'b0;
      end else if (state_q == S_FIX) begin
        if (op_q == ALU_MUL) begin
          fval_q <= 1'b0;
        end else begin
          fval_q  <= 1'b1;
          fprod_q <= prod;
          fsrc1_q <= src1_q;
          fsrc2_q <= src2_q;
        end
      end
    end
  end
`endif

  assign bus.busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = res_q;

endmodule
